// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the decode/write-back slice.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      AOK = 2'd0,
      HLT = 2'd1,
      ADR = 2'd2,
      INS = 2'd3
   } stat_t;

endpackage

// File: rtl/regfile_y86.sv
// 15x64 register file: three async read ports, two sync write ports
// (M wins over E on the same register), sync reset that seeds %rsp.
module regfile_y86
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_RESET = 64'd1016,
   parameter int          NUM_REGS  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m,
   input  logic [3:0]  addr_a,
   output logic [63:0] data_a,
   input  logic [3:0]  addr_b,
   output logic [63:0] data_b,
   input  logic [3:0]  addr_dbg,
   output logic [63:0] data_dbg
);

   logic [63:0] regs [NUM_REGS];

   // Reads see pre-edge contents; ID 15 has no storage and reads as zero.
   always_comb begin
      data_a   = (addr_a   == RNONE) ? 64'd0 : regs[addr_a];
      data_b   = (addr_b   == RNONE) ? 64'd0 : regs[addr_b];
      data_dbg = (addr_dbg == RNONE) ? 64'd0 : regs[addr_dbg];
   end

   // Commit; the M write is issued last so it overrides E on a shared target.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == int'(RSP)) ? RSP_RESET : 64'd0;
         end
      end else if (wr_en) begin
         if (dst_e != RNONE) regs[dst_e] <= val_e;
         if (dst_m != RNONE) regs[dst_m] <= val_m;
      end
   end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode and write-back stage: picks register IDs from icode/rA/rB,
// reads operands combinationally and commits valE/valM at the end of the
// instruction.
module decode_writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_RESET = 64'd1016,
   parameter int          NUM_REGS  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   input  logic [3:0]  dbg_addr,
   output logic [63:0] dbg_data
);

   // Register ID selection; unknown icodes fall through to RNONE everywhere,
   // which also suppresses any write for them.
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      unique case (icode)
         IRRMOVQ: begin
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         IIRMOVQ: dstE = rB;
         IRMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         IMRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         IOPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         ICALL: begin
            srcB = RSP;
            dstE = RSP;
         end
         IRET: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
         end
         IPUSHQ: begin
            srcA = rA;
            srcB = RSP;
            dstE = RSP;
         end
         IPOPQ: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = rA;
         end
         default: begin
            srcA = RNONE;
            srcB = RNONE;
            dstE = RNONE;
            dstM = RNONE;
         end
      endcase
   end

   regfile_y86 #(
      .RSP_RESET (RSP_RESET),
      .NUM_REGS  (NUM_REGS)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wb_en),
      .dst_e    (dstE),
      .val_e    (valE),
      .dst_m    (dstM),
      .val_m    (valM),
      .addr_a   (srcA),
      .data_a   (valA),
      .addr_b   (srcB),
      .data_b   (valB),
      .addr_dbg (dbg_addr),
      .data_dbg (dbg_data)
   );

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: decode table plus register-model scoreboard.
module tb_decode_writeback;

   localparam logic [63:0] RSP_RESET = 64'd1016;

   logic        clk = 1'b0;
   logic        rst, wb_en, cnd;
   logic [3:0]  icode, rA, rB, dbg_addr;
   logic [63:0] valE, valM;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valA, valB, dbg_data;

   decode_writeback #(.RSP_RESET(RSP_RESET), .NUM_REGS(15)) dut (
      .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
      .cnd(cnd), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
      .dstE(dstE), .dstM(dstM), .valA(valA), .valB(valB),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ic, ra, rb;
      logic       c;
      logic [3:0] s_a, s_b, d_e, d_m;
   } vec_t;

   typedef struct {
      logic [3:0]  addr;
      logic [63:0] val;
   } sb_t;

   vec_t        vecs[$];
   sb_t         sb_q[$];
   logic [63:0] model [15];
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_rd(input logic [3:0] a);
      return (a == 4'hF) ? 64'd0 : model[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) model[i] = (i == 4) ? RSP_RESET : 64'd0;
   endtask

   // Push every register's expected value, then drain the queue through dbg.
   task automatic scoreboard_all(input string tag);
      for (int i = 0; i < 15; i++) sb_q.push_back('{addr: 4'(i), val: model[i]});
      while (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         dbg_addr = e.addr;
         #1;
         check($sformatf("%s reg%0d", tag, e.addr), dbg_data, e.val);
      end
   endtask

   // Expected IDs for one instruction, written straight from the ISA table.
   task automatic expect_ids(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                             input logic c, output logic [3:0] s_a, output logic [3:0] s_b,
                             output logic [3:0] d_e, output logic [3:0] d_m);
      s_a = 4'hF; s_b = 4'hF; d_e = 4'hF; d_m = 4'hF;
      if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) s_a = ra;
      if (ic == 4'h9 || ic == 4'hB) s_a = 4'h4;
      if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) s_b = rb;
      if (ic >= 4'h8 && ic <= 4'hB) s_b = 4'h4;
      if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) d_e = rb;
      if (ic >= 4'h8 && ic <= 4'hB) d_e = 4'h4;
      if (ic == 4'h5 || ic == 4'hB) d_m = ra;
   endtask

   // One instruction: check decode and reads before the edge, then commit.
   task automatic run_instr(input string tag, input logic [3:0] ic, input logic [3:0] ra,
                            input logic [3:0] rb, input logic c, input logic [63:0] ve,
                            input logic [63:0] vm, input logic we, input logic rs);
      logic [3:0] s_a, s_b, d_e, d_m;
      icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; wb_en = we; rst = rs;
      #1;
      expect_ids(ic, ra, rb, c, s_a, s_b, d_e, d_m);
      check({tag, " dstE"}, 64'(dstE), 64'(d_e));
      check({tag, " dstM"}, 64'(dstM), 64'(d_m));
      check({tag, " valA"}, valA, model_rd(s_a));
      check({tag, " valB"}, valB, model_rd(s_b));
      @(posedge clk);
      if (rs) model_reset();
      else if (we) begin
         if (d_e != 4'hF) model[d_e] = ve;
         if (d_m != 4'hF) model[d_m] = vm;
      end
      #1;
      rst = 1'b0; wb_en = 1'b0;
      scoreboard_all(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; wb_en = 1'b1; cnd = 1'b0; icode = 4'h3; rA = 4'hF; rB = 4'h7;
      valE = 64'hDEAD; valM = 64'hBEEF; dbg_addr = 4'h0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; wb_en = 1'b0;
      scoreboard_all("reset");
      dbg_addr = 4'hF; #1;
      check("dbg rnone", dbg_data, 64'd0);

      // Decode table: rA=1, rB=6 unless noted.
      vecs.push_back('{4'h0, 4'h1, 4'h6, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF});
      vecs.push_back('{4'h1, 4'h1, 4'h6, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF});
      vecs.push_back('{4'h2, 4'h1, 4'h6, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF});
      vecs.push_back('{4'h2, 4'h1, 4'h6, 1'b1, 4'h1, 4'hF, 4'h6, 4'hF});
      vecs.push_back('{4'h3, 4'hF, 4'h6, 1'b0, 4'hF, 4'hF, 4'h6, 4'hF});
      vecs.push_back('{4'h4, 4'h1, 4'h6, 1'b0, 4'h1, 4'h6, 4'hF, 4'hF});
      vecs.push_back('{4'h5, 4'h1, 4'h6, 1'b0, 4'hF, 4'h6, 4'hF, 4'h1});
      vecs.push_back('{4'h6, 4'h1, 4'h6, 1'b0, 4'h1, 4'h6, 4'h6, 4'hF});
      vecs.push_back('{4'h6, 4'hE, 4'h0, 1'b0, 4'hE, 4'h0, 4'h0, 4'hF});
      vecs.push_back('{4'h7, 4'h1, 4'h6, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF});
      vecs.push_back('{4'h8, 4'h1, 4'h6, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF});
      vecs.push_back('{4'h9, 4'h1, 4'h6, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF});
      vecs.push_back('{4'hA, 4'h1, 4'h6, 1'b0, 4'h1, 4'h4, 4'h4, 4'hF});
      vecs.push_back('{4'hB, 4'h1, 4'h6, 1'b0, 4'h4, 4'h4, 4'h4, 4'h1});
      vecs.push_back('{4'hC, 4'h1, 4'h6, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF});
      vecs.push_back('{4'hF, 4'h4, 4'h4, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF});

      foreach (vecs[k]) begin
         icode = vecs[k].ic; rA = vecs[k].ra; rB = vecs[k].rb; cnd = vecs[k].c;
         #1;
         check($sformatf("dec%0d srcA", k), 64'(srcA), 64'(vecs[k].s_a));
         check($sformatf("dec%0d srcB", k), 64'(srcB), 64'(vecs[k].s_b));
         check($sformatf("dec%0d dstE", k), 64'(dstE), 64'(vecs[k].d_e));
         check($sformatf("dec%0d dstM", k), 64'(dstM), 64'(vecs[k].d_m));
         check($sformatf("dec%0d valA", k), valA, model_rd(vecs[k].s_a));
         check($sformatf("dec%0d valB", k), valB, model_rd(vecs[k].s_b));
      end

      // irmovq into reg2; valB (RNONE) must read 0 in the same cycle.
      run_instr("irmovq", 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1, 1'b0);
      // Illegal icode with wb_en high must not write anything.
      run_instr("illegal", 4'hD, 4'h2, 4'h2, 1'b1, 64'hFFFF, 64'hEEEE, 1'b1, 1'b0);
      // Set up OPq operands, then OPq reg2,reg3.
      run_instr("ld r2", 4'h3, 4'hF, 4'h2, 1'b0, 64'd5, 64'h0, 1'b1, 1'b0);
      run_instr("ld r3", 4'h3, 4'hF, 4'h3, 1'b0, 64'd7, 64'h0, 1'b1, 1'b0);
      icode = 4'h6; rA = 4'h2; rB = 4'h3; #1;
      check("opq valA", valA, 64'd5);
      check("opq valB", valB, 64'd7);
      run_instr("opq", 4'h6, 4'h2, 4'h3, 1'b0, 64'd12, 64'h0, 1'b1, 1'b0);
      // popq %rsp: valM wins over valE on the shared target.
      run_instr("popq rsp", 4'hB, 4'h4, 4'hF, 1'b0, 64'd1024, 64'hBEEF, 1'b1, 1'b0);
      check("popq rsp r4", model[4], 64'hBEEF);
      // popq to a different register: both writes land.
      run_instr("popq r5", 4'hB, 4'h5, 4'hF, 1'b0, 64'hBEF7, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0);
      // cmov not taken, then taken.
      run_instr("cmov nt", 4'h2, 4'h1, 4'h6, 1'b0, 64'd99, 64'h0, 1'b1, 1'b0);
      run_instr("cmov t", 4'h2, 4'h1, 4'h6, 1'b1, 64'd99, 64'h0, 1'b1, 1'b0);
      // Full-width value into the top register.
      run_instr("mrmovq", 4'h5, 4'hE, 4'h2, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      // wb_en low: no change.
      run_instr("wb off", 4'h3, 4'hF, 4'h7, 1'b0, 64'd77, 64'h0, 1'b0, 1'b0);
      // Reset alongside a pushq write: reset wins.
      run_instr("rst push", 4'hA, 4'h1, 4'hF, 1'b0, 64'd1008, 64'h0, 1'b1, 1'b1);
      dbg_addr = 4'h4; #1;
      check("rst r4", dbg_data, RSP_RESET);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
